fetch_unit: RTL and testbench

- Instruction fetch stage that produces the instruction fields the control decoder consumes (opcode, funct), and consumes the decoder's pcsrc and jump outputs to select the next PC.
- Sits between instruction memory and controller/datapath, and owns the PC register.
- Talks to a variable-latency instruction memory over a req/ack handshake.
- Holds each instruction stable until the datapath commits it.

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_unit_pc_next_sel.sv | 27 ++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcode encodings, fetch FSM state codes and default reset PC.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection: jump target, sign-extended branch target, or sequential pc+4.
module pc_next_sel #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pcplus4,
   input  logic [25:0]       instr,
   input  logic              pcsrc,
   input  logic              jump,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] branch_off;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] jump_target;

   always_comb begin
      branch_off    = {{(ADDR_W-16){instr[15]}}, instr[15:0]} << 2;
      branch_target = pcplus4 + branch_off;
      jump_target   = {pcplus4[ADDR_W-1:28], instr[25:0], 2'b00};
      next_pc       = pcplus4;
      if (jump)
         next_pc = jump_target;
      else if (pcsrc)
         next_pc = branch_target;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and holds
// each instruction until the datapath commits it.
module fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              advance,
   input  logic              pcsrc,
   input  logic              jump,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic [5:0]        funct,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pcplus4
);

   logic [1:0]        state;
   logic [ADDR_W-1:0] next_pc;

   // Request is a pure function of state, so it drops the cycle after reset is sampled.
   assign imem_req  = (state == FETCH);
   assign imem_addr = pc;
   assign opcode    = instr[31:26];
   assign funct     = instr[5:0];
   assign pcplus4   = pc + {{(ADDR_W-3){1'b0}}, 3'd4};

   pc_next_sel #(
      .ADDR_W (ADDR_W)
   ) u_pc_next_sel (
      .pcplus4 (pcplus4),
      .instr   (instr[25:0]),
      .pcsrc   (pcsrc),
      .jump    (jump),
      .next_pc (next_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (advance) begin
                  pc          <= next_pc;
                  instr_valid <= 1'b0;
                  state       <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/jump fetch, wait states,
// PC wrap and reset in the middle of a fetch.
module tb_fetch_unit;
   import mips_pkg::*;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        advance;
   logic        pcsrc;
   logic        jump;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pcplus4;

   int total = 0;
   int bad   = 0;

   fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .advance     (advance),
      .pcsrc       (pcsrc),
      .jump        (jump),
      .instr       (instr),
      .opcode      (opcode),
      .funct       (funct),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pcplus4     (pcplus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      advance = 1'b0; pcsrc = 1'b0; jump = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req cyc%0d got=%0h exp=0", i, imem_req); end
         total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc cyc%0d got=%0h exp=0", i, pc); end
         total++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin bad++; $display("FAIL rst_instr cyc%0d got=%0h/%0h exp=0/0", i, instr_valid, instr); end
      end
      reset = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%0h exp=0", imem_req); end
      step();
      total++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin bad++; $display("FAIL idle_ack_ignored got=%0h/%0h exp=0/0", instr_valid, instr); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_fetch got=%0h/%0h exp=1/0", imem_req, imem_addr); end
      imem_ack = 1'b0;
   endtask

   task automatic test_sequential();
      logic [31:0] words [3];
      logic [5:0]  ops   [3];
      words[0] = 32'h2001_0005; ops[0] = OP_ADDI;
      words[1] = 32'hAC01_0000; ops[1] = OP_SW;
      words[2] = 32'h0000_0000; ops[2] = OP_RTYPE;
      imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
      step();
      imem_ack = 1'b0;
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%0h exp=1", instr_valid); end
      total++; if (opcode !== OP_RTYPE || funct !== 6'h20) begin bad++; $display("FAIL seq_fields got=%0h/%0h exp=0/20", opcode, funct); end
      total++; if (imem_req !== 1'b0 || instr !== 32'h0022_1820) begin bad++; $display("FAIL seq_hold got=%0h/%0h exp=0/00221820", imem_req, instr); end
      advance = 1'b1;
      step();
      advance = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL seq_next got=%0h/%0h exp=1/4", imem_req, imem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_valid_clr got=%0h exp=0", instr_valid); end
      for (int i = 0; i < 3; i++) begin
         imem_ack = 1'b1; imem_rdata = words[i];
         step();
         imem_ack = 1'b0;
         total++; if (opcode !== ops[i]) begin bad++; $display("FAIL seq_op%0d got=%0h exp=%0h", i, opcode, ops[i]); end
         advance = 1'b1;
         step();
         advance = 1'b0;
      end
      total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL seq_pc10 got=%0h exp=10", imem_addr); end
   endtask

   task automatic test_branch();
      imem_ack = 1'b1; imem_rdata = 32'h1000_FFFF;
      step();
      imem_ack = 1'b0;
      total++; if (opcode !== OP_BEQ) begin bad++; $display("FAIL br_op got=%0h exp=%0h", opcode, OP_BEQ); end
      pcsrc = 1'b1; advance = 1'b1;
      step();
      pcsrc = 1'b0; advance = 1'b0;
      total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL br_neg got=%0h exp=10", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h1000_0003;
      step();
      imem_ack = 1'b0;
      pcsrc = 1'b1; advance = 1'b1;
      step();
      pcsrc = 1'b0; advance = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin bad++; $display("FAIL br_pos got=%0h/%0h exp=1/20", imem_req, imem_addr); end
   endtask

   task automatic test_jump();
      imem_ack = 1'b1; imem_rdata = 32'h0800_0040;
      step();
      imem_ack = 1'b0;
      total++; if (opcode !== OP_J) begin bad++; $display("FAIL j_op got=%0h exp=%0h", opcode, OP_J); end
      jump = 1'b1; pcsrc = 1'b1; advance = 1'b1;
      step();
      jump = 1'b0; pcsrc = 1'b0; advance = 1'b0;
      total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL j_prio got=%0h exp=100", imem_addr); end
   endtask

   task automatic test_wait_states();
      for (int i = 0; i < 3; i++) begin
         advance = (i == 1);
         step();
         advance = 1'b0;
         total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL ws_addr%0d got=%0h/%0h exp=1/100", i, imem_req, imem_addr); end
         total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ws_valid%0d got=%0h exp=0", i, instr_valid); end
      end
      imem_ack = 1'b1; imem_rdata = 32'h8C43_0008;
      step();
      imem_ack = 1'b0;
      total++; if (opcode !== OP_LW || funct !== 6'h08) begin bad++; $display("FAIL ws_lw got=%0h/%0h exp=%0h/08", opcode, funct, OP_LW); end
      for (int i = 0; i < 4; i++) begin
         imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
         step();
         total++; if (instr !== 32'h8C43_0008 || pc !== 32'h100 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            bad++; $display("FAIL stall%0d got=%0h/%0h/%0h/%0h exp=8c430008/100/1/0", i, instr, pc, instr_valid, imem_req);
         end
      end
      imem_ack = 1'b0;
      advance = 1'b1;
      step();
      advance = 1'b0;
      total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL ws_next got=%0h exp=104", imem_addr); end
   endtask

   task automatic test_mid_reset();
      step();
      reset = 1'b1;
      step();
      total++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mr_rst got=%0h/%0h/%0h exp=0/0/0", imem_req, pc, instr_valid); end
      reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      total++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mr_stale got=%0h/%0h exp=0/0", instr, instr_valid); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL mr_restart got=%0h/%0h exp=1/0", imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      imem_ack = 1'b1; imem_rdata = 32'h1000_FFFE;
      step();
      imem_ack = 1'b0;
      pcsrc = 1'b1; advance = 1'b1;
      step();
      pcsrc = 1'b0; advance = 1'b0;
      total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_br got=%0h exp=fffffffc", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
      step();
      imem_ack = 1'b0;
      total++; if (pcplus4 !== 32'h0) begin bad++; $display("FAIL wr_pcplus4 got=%0h exp=0", pcplus4); end
      advance = 1'b1;
      step();
      advance = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wr_seq got=%0h/%0h exp=1/0", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_wait_states();
      test_mid_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
